// File: rtl/float_to_int_pkg.sv
// Shared float parameterisation and exponent classification helpers for the
// float<->int converter pair.
package float_to_int_pkg;

  localparam int DEF_MANTISSA_SIZE = 23;
  localparam int DEF_EXPONENT_SIZE = 8;
  localparam int DEF_INT_SIZE      = 32;

  typedef enum logic {SH_RIGHT = 1'b0, SH_LEFT = 1'b1} shift_dir_e;

  // Result override chosen in stage 2, applied in stage 4.
  typedef enum logic [2:0] {
    SPC_NONE = 3'd0,
    SPC_ZERO = 3'd1,
    SPC_SAT  = 3'd2,
    SPC_NAN  = 3'd3,
    SPC_MIN  = 3'd4
  } spc_e;

  function automatic int float_size(input int mant_w, input int exp_w);
    return 1 + exp_w + mant_w;
  endfunction

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int sign_pos(input int mant_w, input int exp_w);
    return exp_w + mant_w;
  endfunction

  function automatic logic exp_all_ones(input logic [31:0] exp, input int unsigned w);
    logic [31:0] mask;
    mask = (32'h1 << w) - 32'h1;
    return (exp & mask) == mask;
  endfunction

  function automatic logic is_zero(input logic [31:0] exp);
    return exp == 32'h0;
  endfunction

  function automatic logic is_inf(input logic [31:0] exp, input logic [63:0] mant,
                                  input int unsigned w);
    return exp_all_ones(exp, w) && (mant == 64'h0);
  endfunction

  function automatic logic is_nan(input logic [31:0] exp, input logic [63:0] mant,
                                  input int unsigned w);
    return exp_all_ones(exp, w) && (mant != 64'h0);
  endfunction

endpackage

// File: rtl/float_align_shift.sv
// Bidirectional log-stage barrel shift of the float magnitude into the
// integer-width field.
module float_align_shift
  import float_to_int_pkg::*;
#(
  parameter int M_W   = 24,
  parameter int OUT_W = 32,
  parameter int SHW   = 5
) (
  input  logic [M_W-1:0]   m,
  input  shift_dir_e       dir,
  input  logic [SHW-1:0]   amt,
  output logic [OUT_W-1:0] mag
);

  logic [SHW:0][OUT_W-1:0] st;

  assign st[0] = OUT_W'(m);

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    assign st[k+1] = !amt[k]          ? st[k] :
                     (dir == SH_LEFT) ? (st[k] << (1 << k)) :
                                        (st[k] >> (1 << k));
  end

  assign mag = st[SHW];

endmodule

// File: rtl/float_to_int.sv
// Four-stage float to saturated, truncated two's-complement integer converter
// with a signed exponent offset for free fixpoint scaling.
module float_to_int
  import float_to_int_pkg::*;
#(
  parameter int MANTISSA_SIZE = DEF_MANTISSA_SIZE,
  parameter int EXPONENT_SIZE = DEF_EXPONENT_SIZE,
  parameter int INT_SIZE      = DEF_INT_SIZE
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic signed [EXPONENT_SIZE-1:0]        offset,
  input  logic                                   in_valid,
  input  logic [MANTISSA_SIZE+EXPONENT_SIZE:0]   in,
  output logic                                   out_valid,
  output logic [INT_SIZE-1:0]                    out,
  output logic                                   out_overflow
);

  localparam int FLOAT_SIZE = float_size(MANTISSA_SIZE, EXPONENT_SIZE);
  localparam int SIGN_POS   = sign_pos(MANTISSA_SIZE, EXPONENT_SIZE);
  localparam int BIAS       = exp_bias(EXPONENT_SIZE);
  localparam int EW         = EXPONENT_SIZE + 2;
  localparam int SHW        = $clog2(INT_SIZE);
  localparam int STAGES     = 4;

  localparam logic signed [EW-1:0] E_SAT  = EW'(INT_SIZE - 1);
  localparam logic signed [EW-1:0] E_LEFT = EW'(MANTISSA_SIZE);
  localparam logic [INT_SIZE-1:0]  INT_MIN = {1'b1, {(INT_SIZE-1){1'b0}}};
  localparam logic [INT_SIZE-1:0]  INT_MAX = {1'b0, {(INT_SIZE-1){1'b1}}};

  typedef struct packed {
    logic                   sign;
    logic                   zero;
    logic                   inf;
    logic                   nan;
    logic                   mant_zero;
    logic [MANTISSA_SIZE:0] m;
    logic [EW-1:0]          e;
  } s1_t;

  typedef struct packed {
    logic                   sign;
    spc_e                   spc;
    shift_dir_e             dir;
    logic [SHW-1:0]         amt;
    logic [MANTISSA_SIZE:0] m;
  } s2_t;

  typedef struct packed {
    logic                sign;
    spc_e                spc;
    logic [INT_SIZE-1:0] mag;
  } s3_t;

  logic [STAGES:0] vld_pipe;
  s1_t s1, s1_c;
  s2_t s2, s2_c;
  s3_t s3;
  logic [INT_SIZE-1:0] mag_c;
  logic [INT_SIZE-1:0] res_c;
  logic                ovf_c;

  logic [EXPONENT_SIZE-1:0] exp_f;
  logic [MANTISSA_SIZE-1:0] mant_f;
  logic signed [EW-1:0]     e_c;
  logic signed [EW-1:0]     e2;
  logic signed [EW-1:0]     diff_c;

  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) vld_pipe[STAGES:1] <= '0;
    else         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // Stage 1: classify and form the effective exponent (wide enough to never wrap).
  assign exp_f  = in[FLOAT_SIZE-2 -: EXPONENT_SIZE];
  assign mant_f = in[MANTISSA_SIZE-1:0];
  assign e_c    = $signed({2'b00, exp_f}) - $signed(EW'(BIAS)) + EW'(offset);

  always_comb begin
    s1_c           = '0;
    s1_c.sign      = in[SIGN_POS];
    s1_c.zero      = is_zero(32'(exp_f));
    s1_c.inf       = is_inf(32'(exp_f), 64'(mant_f), EXPONENT_SIZE);
    s1_c.nan       = is_nan(32'(exp_f), 64'(mant_f), EXPONENT_SIZE);
    s1_c.mant_zero = (mant_f == '0);
    s1_c.m         = {1'b1, mant_f};
    s1_c.e         = e_c;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          s1 <= '0;
    else if (vld_pipe[0]) s1 <= s1_c;
  end

  // Stage 2: shift direction/amount and special-case selection.
  assign e2     = $signed(s1.e);
  assign diff_c = (e2 >= E_LEFT) ? (e2 - E_LEFT) : (E_LEFT - e2);

  always_comb begin
    s2_c      = '0;
    s2_c.sign = s1.sign;
    s2_c.m    = s1.m;
    s2_c.dir  = (e2 >= E_LEFT) ? SH_LEFT : SH_RIGHT;
    if (s1.nan)                    s2_c.spc = SPC_NAN;
    else if (s1.inf)               s2_c.spc = SPC_SAT;
    else if (s1.zero || e2 < 0)    s2_c.spc = SPC_ZERO;
    else if (e2 >= E_SAT)
      s2_c.spc = (s1.sign && e2 == E_SAT && s1.mant_zero) ? SPC_MIN : SPC_SAT;
    else                           s2_c.spc = SPC_NONE;
    s2_c.amt = (s2_c.spc == SPC_NONE) ? SHW'(diff_c) : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          s2 <= '0;
    else if (vld_pipe[1]) s2 <= s2_c;
  end

  float_align_shift #(
    .M_W   (MANTISSA_SIZE + 1),
    .OUT_W (INT_SIZE),
    .SHW   (SHW)
  ) u_shift (
    .m   (s2.m),
    .dir (s2.dir),
    .amt (s2.amt),
    .mag (mag_c)
  );

  // Stage 3: aligned unsigned magnitude.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) s3 <= '0;
    else if (vld_pipe[2]) begin
      s3.sign <= s2.sign;
      s3.spc  <= s2.spc;
      s3.mag  <= mag_c;
    end
  end

  // Stage 4: negate and apply overrides; normal magnitudes are < 2^(INT_SIZE-1).
  always_comb begin
    res_c = s3.sign ? (~s3.mag + 1'b1) : s3.mag;
    ovf_c = 1'b0;
    case (s3.spc)
      SPC_ZERO: res_c = '0;
      SPC_NAN:  begin res_c = '0; ovf_c = 1'b1; end
      SPC_SAT:  begin res_c = s3.sign ? INT_MIN : INT_MAX; ovf_c = 1'b1; end
      SPC_MIN:  res_c = INT_MIN;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out          <= '0;
      out_overflow <= 1'b0;
    end else if (vld_pipe[3]) begin
      out          <= res_c;
      out_overflow <= ovf_c;
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_float_to_int.sv
// Randomised and directed checks of float_to_int against a real-arithmetic
// reference model, including latency and mid-stream reset.
module tb_float_to_int;

  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic signed [7:0] offset = '0;
  logic              in_valid = 1'b0;
  logic [31:0]       in = '0;
  logic              out_valid;
  logic [31:0]       out;
  logic              out_overflow;

  typedef struct {
    logic [31:0] v;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  float_to_int dut (
    .clk          (clk),
    .resetn       (resetn),
    .offset       (offset),
    .in_valid     (in_valid),
    .in           (in),
    .out_valid    (out_valid),
    .out          (out),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference: exact real value, truncated toward zero, saturated to int32.
  function automatic void model(input logic [31:0] f, input logic signed [7:0] off,
                                output logic [31:0] v, output logic ovf);
    int  ex, e;
    real r;
    ex = int'(f[30:23]);
    if (ex == 255) begin
      ovf = 1'b1;
      v   = (f[22:0] != 0) ? 32'h0 : (f[31] ? 32'h80000000 : 32'h7FFFFFFF);
    end else if (ex == 0) begin
      v = 32'h0; ovf = 1'b0;
    end else begin
      e = ex - 127 + int'(off);
      r = real'(int'(f[22:0]) + 8388608) * (2.0 ** (e - 23));
      if (f[31]) r = -r;
      if (r >= 2.0 ** 31)         begin v = 32'h7FFFFFFF; ovf = 1'b1; end
      else if (r < -(2.0 ** 31))  begin v = 32'h80000000; ovf = 1'b1; end
      else                        begin v = $rtoi(r);     ovf = 1'b0; end
    end
  endfunction

  task automatic drive(input logic vld, input logic [31:0] f, input logic signed [7:0] off);
    @(posedge clk); #1;
    in_valid = vld;
    in       = f;
    offset   = off;
  endtask

  task automatic send_exp(input logic [31:0] f, input logic signed [7:0] off,
                          input logic [31:0] v, input logic ovf);
    exp_t e;
    drive(1'b1, f, off);
    e.v = v; e.ovf = ovf; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic send_model(input logic [31:0] f, input logic signed [7:0] off);
    logic [31:0] v;
    logic        ovf;
    model(f, off, v, ovf);
    send_exp(f, off, v, ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, 8'($urandom));
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); t++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetn && out_valid) begin
      if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk("out", 64'(out), 64'(e.v));
        chk("ovf", 64'(out_overflow), 64'(e.ovf));
        chk("lat", 64'(cyc), 64'(e.cyc + LAT));
      end
    end
  end

  typedef struct {
    logic [31:0]       f;
    logic signed [7:0] off;
    logic [31:0]       v;
    logic              ovf;
  } vec_t;

  vec_t dir_tab[$] = '{
    '{32'hC0200000,  8'sd0,   32'hFFFFFFFE, 1'b0},
    '{32'h3F000000,  8'sd0,   32'h00000000, 1'b0},
    '{32'h00000001,  8'sd0,   32'h00000000, 1'b0},
    '{32'h3FC00000,  8'sd8,   32'h00000180, 1'b0},
    '{32'h3FC00000, -8'sd1,   32'h00000000, 1'b0},
    '{32'h4B000000,  8'sd0,   32'h00800000, 1'b0},
    '{32'h4F000000,  8'sd0,   32'h7FFFFFFF, 1'b1},
    '{32'hCF000000,  8'sd0,   32'h80000000, 1'b0},
    '{32'hFF800000,  8'sd0,   32'h80000000, 1'b1},
    '{32'h7FC00000,  8'sd0,   32'h00000000, 1'b1},
    '{32'h7F800000, -8'sd100, 32'h7FFFFFFF, 1'b1},
    '{32'h4EFFFFFF,  8'sd0,   32'h7FFFFF80, 1'b0},
    '{32'hCF000001,  8'sd0,   32'h80000000, 1'b1},
    '{32'h80000000,  8'sd0,   32'h00000000, 1'b0},
    '{32'h3F800000,  8'sd30,  32'h40000000, 1'b0},
    '{32'h3F800000,  8'sd31,  32'h7FFFFFFF, 1'b1},
    '{32'h00400000,  8'sd100, 32'h00000000, 1'b0},
    '{32'hBF7D70A4,  8'sd0,   32'h00000000, 1'b0}
  };

  initial begin
    logic [31:0] f;
    logic [7:0]  ex;
    logic signed [7:0] off;

    #12;
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_ovf", 64'(out_overflow), 64'd0);
    chk("rst_vld", 64'(out_valid), 64'd0);
    @(posedge clk); #3 resetn = 1'b1;
    idle(2);

    // Single strobe, then the directed table with gaps and back-to-back runs.
    send_exp(32'h3F800000, 8'sd0, 32'h00000001, 1'b0);
    idle(6);
    foreach (dir_tab[i]) begin
      send_exp(dir_tab[i].f, dir_tab[i].off, dir_tab[i].v, dir_tab[i].ovf);
      if (i % 3 == 2) idle(1);
    end
    idle(6);
    drain();

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      case ($urandom_range(0, 9))
        0:       ex = 8'd0;
        1:       ex = 8'd255;
        2:       ex = 8'($urandom);
        default: ex = 8'($urandom_range(110, 165));
      endcase
      f = {1'($urandom), ex, ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom)};
      off = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(int'($urandom_range(0, 16)) - 8);
      send_model(f, off);
    end
    idle(6);
    drain();

    // Asynchronous reset with three items in flight.
    send_model(32'h40400000, 8'sd0);
    send_model(32'hC1200000, 8'sd2);
    send_model(32'h3F800000, 8'sd4);
    idle(1);
    @(posedge clk); #3 resetn = 1'b0;
    q.delete();
    #1;
    chk("rst_async_vld", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_hold_vld", 64'(out_valid), 64'd0);
    end
    chk("rst_hold_out", 64'(out), 64'd0);
    @(posedge clk); #3 resetn = 1'b1;
    idle(3);
    send_exp(32'h42F60000, 8'sd0, 32'h0000007B, 1'b0);
    idle(8);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
# float_to_int

Pipelined float-to-signed-integer converter; the inverse path of the team's integer-to-float converter and sharing its parameterisation. Accepts one IEEE-style float per clock with a valid strobe, applies a signed exponent offset (so fixpoint results come out at no extra cost), and produces a saturated, truncated two's-complement integer 4 cycles later. Sits between float arithmetic units and integer or fixpoint consumers (rasterizer, DAC, address logic).

## Interface
- MANTISSA_SIZE, 23, stored mantissa bits (hidden bit not stored)
- EXPONENT_SIZE, 8, exponent bits; bias = 2^(EXPONENT_SIZE-1)-1
- INT_SIZE, 32, output width; must be >= MANTISSA_SIZE+2
- FLOAT_SIZE, 1+EXPONENT_SIZE+MANTISSA_SIZE, derived, not overridable
- clk  in  1  clock; one clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- offset  in  EXPONENT_SIZE signed  added to the unbiased exponent; +8 yields Q.8 fixpoint (×256), -1 halves
- in_valid  in  1  qualifies in/offset this cycle
- in  in  FLOAT_SIZE  {sign, exponent, mantissa}
- out_valid  out  1  qualifies out/out_overflow
- out  out  INT_SIZE  signed result
- out_overflow  out  1  result saturated or input was NaN

## Operation
- Effective exponent e = biased_exp - bias + offset, computed signed in EXPONENT_SIZE+2 bits; never wraps.
- Magnitude m = {1, mantissa}; value = m × 2^(e - MANTISSA_SIZE).
- Rounding: truncate toward zero (-2.5 → -2, 0.99 → 0).
- Biased exponent 0 (zero, denormals): result 0, overflow 0 (denormals flushed).
- e < 0: result 0, overflow 0.
- e >= INT_SIZE-1: saturate; positive → 2^(INT_SIZE-1)-1, negative → -2^(INT_SIZE-1); overflow 1. Exception: negative, e == INT_SIZE-1, mantissa field 0 → exact minimum integer, overflow 0.
- Biased exponent all-ones: infinity saturates as above with overflow 1 regardless of offset; NaN → 0, overflow 1.
- offset only affects finite non-zero inputs.
- No backpressure; one conversion per clock sustained, bubbles allowed anywhere.

## Timing
- Stage 1: register sign, classification (zero/inf/nan), m, e; valid[1] <= in_valid.
- Stage 2: decide left shift (e >= MANTISSA_SIZE, amount e-MANTISSA_SIZE) or right shift (amount MANTISSA_SIZE-e); decide saturate/zero/min-int special cases.
- Stage 3: perform shift into INT_SIZE-bit unsigned magnitude.
- Stage 4: conditional two's-complement negate, apply special-case override, register out, out_overflow, out_valid.
- Latency exactly 4: in sampled with in_valid at edge N → out_valid high after edge N+4 for one cycle per input.
- out/out_overflow hold last value when out_valid is low; consumers must ignore them.
- Reset: out = 0, out_overflow = 0, out_valid = 0, all valid stages 0; data registers also cleared to 0.
- Reset mid-stream: all in-flight items dropped; no out_valid until 4 cycles after the first in_valid sampled post-release.
- Back-to-back inputs produce back-to-back outputs in order.

## Structure
- Shared float parameter include (also used by the int-to-float block): FLOAT_SIZE, EXPONENT_BIAS, SIGN_POS derivations, classification helpers (is_zero, is_inf, is_nan exponent tests).
- One sub-module: float_align_shift — combinational bidirectional barrel shift of m into INT_SIZE bits by a direction flag and amount; instantiated between stage 2 and stage 3 registers.
- Valid pipeline is a 4-bit shift register, separate from the data path.

## Test plan
- 0x3F800000 (1.0), offset 0, single strobe → out_valid exactly 4 cycles later, out = 1, overflow 0.
- 0xC0200000 (-2.5) → 0xFFFFFFFE; 0x3F000000 (0.5) → 0; denormal 0x00000001 → 0; all overflow 0.
- 0x3FC00000 (1.5) with offset +8 → 384; with offset -1 → 0; 0x4B000000 (2^23) offset 0 → 0x00800000.
- 0x4F000000 (2^31) → 0x7FFFFFFF, overflow 1; 0xCF000000 (-2^31) → 0x80000000, overflow 0; 0xFF800000 (-inf) → 0x80000000, overflow 1; 0x7FC00000 (NaN) → 0, overflow 1.
- 1000 random floats/offsets streamed with random in_valid gaps → outputs in order, 4-cycle latency each, match reference model bit-exact.
- resetn asserted asynchronously with 3 items in flight → out_valid drops immediately, none of those items emerge; next input after release appears 4 cycles later.
